// File: rtl/io_bridge_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : io_bridge_pkg                                           |
// | Brief  : Shared I/O register offsets, CTRL bit indices and the   |
// |          timer control struct used by the I/O bridge.            |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package io_bridge_pkg;

  // Register offsets inside the 256-byte I/O window (word aligned)
  localparam logic [7:0] IO_GPIO_OUT = 8'h00;
  localparam logic [7:0] IO_GPIO_IN  = 8'h04;
  localparam logic [7:0] IO_CTRL     = 8'h08;
  localparam logic [7:0] IO_LOAD     = 8'h0C;
  localparam logic [7:0] IO_COUNT    = 8'h10;
  localparam logic [7:0] IO_STATUS   = 8'h14;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_RELOAD_BIT = 1;
  localparam int CTRL_IRQEN_BIT  = 2;

  // Field order puts en at bit 0 so the struct matches the CTRL layout
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } timer_ctrl_t;

endpackage : io_bridge_pkg
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : io_timer                                                |
// | Brief  : Prescaled 32-bit down-counter with LOAD, CTRL, sticky   |
// |          expired flag (write-1-to-clear) and level interrupt.    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module io_timer
  import io_bridge_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr,
  input  logic [7:0]  i_off,
  input  logic [31:0] i_wd,
  output logic [31:0] o_count,
  output logic [31:0] o_load,
  output timer_ctrl_t o_ctrl,
  output logic        o_expired,
  output logic        o_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic [31:0]   r_count;
  logic [31:0]   r_load;
  timer_ctrl_t   r_ctrl;
  logic          r_expired;

  logic w_tick;
  logic w_hw_set;
  logic w_wr_ctrl;
  logic w_wr_load;
  logic w_wr_status;

  assign w_tick      = r_ctrl.en && (r_pre == C_PRE_LAST);
  assign w_hw_set    = w_tick && (r_count == 32'd0);
  assign w_wr_ctrl   = i_wr && (i_off == IO_CTRL);
  assign w_wr_load   = i_wr && (i_off == IO_LOAD);
  assign w_wr_status = i_wr && (i_off == IO_STATUS);

  // Prescaler, counter, control and expired-flag state updates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_load    <= '0;
      r_ctrl    <= '0;
      r_expired <= 1'b0;
    end else begin
      if (!r_ctrl.en || w_tick) r_pre <= '0;
      else                      r_pre <= r_pre + PW'(1);

      // A LOAD write overrides whatever the tick would have done
      if (w_wr_load) begin
        r_count <= i_wd;
      end else if (w_tick) begin
        if (r_count != 32'd0)      r_count <= r_count - 32'd1;
        else if (r_ctrl.auto_reload) r_count <= r_load;
      end

      if (w_wr_load) r_load <= i_wd;

      // Software CTRL write wins over the one-shot hardware disable
      if (w_wr_ctrl) begin
        r_ctrl.en          <= i_wd[CTRL_EN_BIT];
        r_ctrl.auto_reload <= i_wd[CTRL_RELOAD_BIT];
        r_ctrl.irq_en      <= i_wd[CTRL_IRQEN_BIT];
      end else if (w_hw_set && !r_ctrl.auto_reload) begin
        r_ctrl.en <= 1'b0;
      end

      // Hardware set wins over a simultaneous write-1-to-clear
      if (w_hw_set)                     r_expired <= 1'b1;
      else if (w_wr_status && i_wd[0])  r_expired <= 1'b0;
    end
  end

  assign o_count   = r_count;
  assign o_load    = r_load;
  assign o_ctrl    = r_ctrl;
  assign o_expired = r_expired;
  assign o_irq     = r_expired & r_ctrl.irq_en;

endmodule : io_timer
`default_nettype wire

// File: rtl/io_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : io_bridge                                               |
// | Brief  : Data-port bridge between core and dmem; decodes a       |
// |          256-byte I/O window holding GPIO and a timer, all other |
// |          addresses pass through to dmem.                         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = 32'hFFFF_FF00,
  parameter int          PRESCALE = 4,
  parameter int          MEM_AW   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out,
  output logic              timer_irq
);

  logic        w_is_io;
  logic [7:0]  w_off;
  logic        w_io_wr;
  logic [31:0] w_io_rdata;

  logic [31:0] r_gpio_out;
  logic [31:0] r_gpio_s1;
  logic [31:0] r_gpio_s2;

  logic [31:0] w_count;
  logic [31:0] w_load;
  timer_ctrl_t w_ctrl;
  logic        w_expired;

  // Byte lanes within a word are ignored for register selection
  assign w_is_io = (addr[31:8] == IO_BASE[31:8]);
  assign w_off   = {addr[7:2], 2'b00};
  assign w_io_wr = we & w_is_io;

  assign mem_we   = we & ~w_is_io;
  assign mem_addr = addr[MEM_AW-1:0];
  assign mem_wd   = wd;

  // GPIO output register and two-flop input synchronizer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gpio_out <= '0;
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
    end else begin
      if (w_io_wr && (w_off == IO_GPIO_OUT)) r_gpio_out <= wd;
      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;
    end
  end

  io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clock),
    .rst       (reset),
    .i_wr      (w_io_wr),
    .i_off     (w_off),
    .i_wd      (wd),
    .o_count   (w_count),
    .o_load    (w_load),
    .o_ctrl    (w_ctrl),
    .o_expired (w_expired),
    .o_irq     (timer_irq)
  );

  // I/O read mux; unmapped offsets read as zero
  always_comb begin
    w_io_rdata = 32'h0;
    case (w_off)
      IO_GPIO_OUT: w_io_rdata = r_gpio_out;
      IO_GPIO_IN:  w_io_rdata = r_gpio_s2;
      IO_CTRL:     w_io_rdata = {29'h0, w_ctrl};
      IO_LOAD:     w_io_rdata = w_load;
      IO_COUNT:    w_io_rdata = w_count;
      IO_STATUS:   w_io_rdata = {31'h0, w_expired};
      default:     w_io_rdata = 32'h0;
    endcase
  end

  assign rd       = w_is_io ? w_io_rdata : mem_rd;
  assign gpio_out = r_gpio_out;

endmodule : io_bridge
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_io_bridge                                            |
// | Brief  : Directed self-checking bench for io_bridge.             |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_io_bridge;

  localparam logic [31:0] C_BASE = 32'hFFFF_FF00;

  logic        clock;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        timer_irq;

  int n_pass;
  int n_total;

  logic [31:0] r_mem [0:1023];

  io_bridge #(
    .IO_BASE  (C_BASE),
    .PRESCALE (4),
    .MEM_AW   (10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple dmem model: combinational read, write on rising edge
  assign mem_rd = r_mem[mem_addr];
  always @(posedge clock) if (mem_we) r_mem[mem_addr] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_mem_we);
    addr = a;
    wd   = d;
    we   = 1'b1;
    #1;
    chk("mem_we", {31'h0, mem_we}, {31'h0, exp_mem_we});
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    we      = 1'b0;
    addr    = 32'h0;
    wd      = 32'h0;
    gpio_in = 32'h0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Reset state
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    rd_chk("rst_count", C_BASE + 32'h10, 32'h0);
    rd_chk("rst_ctrl", C_BASE + 32'h08, 32'h0);
    rd_chk("rst_status", C_BASE + 32'h14, 32'h0);
    rd_chk("rst_load", C_BASE + 32'h0C, 32'h0);

    // 1. Pass-through to dmem
    wr(32'h40, 32'hDEADBEEF, 1'b1);
    rd_chk("mem_load", 32'h40, 32'hDEADBEEF);
    chk("mem_addr", {22'h0, mem_addr}, 32'h40);

    // 2. GPIO out and synchronized GPIO in
    wr(C_BASE, 32'hA5A5_0F0F, 1'b0);
    chk("gpio_out", gpio_out, 32'hA5A5_0F0F);
    rd_chk("gpio_out_rb", C_BASE, 32'hA5A5_0F0F);
    gpio_in = 32'h1234;
    cyc(1);
    rd_chk("gpio_in_1cyc", C_BASE + 32'h04, 32'h0);
    cyc(1);
    rd_chk("gpio_in_2cyc", C_BASE + 32'h04, 32'h1234);

    // 3. One-shot timer, LOAD=3, CTRL=en|irq_en
    wr(C_BASE + 32'h0C, 32'd3, 1'b0);
    wr(C_BASE + 32'h08, 32'h5, 1'b0);
    rd_chk("os_count3", C_BASE + 32'h10, 32'd3);
    cyc(3);
    rd_chk("os_count3_hold", C_BASE + 32'h10, 32'd3);
    cyc(1);
    rd_chk("os_count2", C_BASE + 32'h10, 32'd2);
    cyc(4);
    rd_chk("os_count1", C_BASE + 32'h10, 32'd1);
    cyc(4);
    rd_chk("os_count0", C_BASE + 32'h10, 32'd0);
    rd_chk("os_not_exp", C_BASE + 32'h14, 32'd0);
    chk("os_irq_low", {31'h0, timer_irq}, 32'h0);
    cyc(4);
    rd_chk("os_expired", C_BASE + 32'h14, 32'd1);
    chk("os_irq", {31'h0, timer_irq}, 32'h1);
    rd_chk("os_en_clr", C_BASE + 32'h08, 32'h4);
    rd_chk("os_count_stay", C_BASE + 32'h10, 32'd0);
    cyc(8);
    rd_chk("os_count_stay2", C_BASE + 32'h10, 32'd0);
    wr(C_BASE + 32'h14, 32'h1, 1'b0);
    rd_chk("os_w1c", C_BASE + 32'h14, 32'd0);
    chk("os_irq_clr", {31'h0, timer_irq}, 32'h0);

    // 4. Auto-reload, LOAD=2, CTRL=0x7
    wr(C_BASE + 32'h0C, 32'd2, 1'b0);
    wr(C_BASE + 32'h08, 32'h7, 1'b0);
    cyc(11);
    rd_chk("ar_not_yet", C_BASE + 32'h14, 32'd0);
    cyc(1);
    rd_chk("ar_exp1", C_BASE + 32'h14, 32'd1);
    chk("ar_irq1", {31'h0, timer_irq}, 32'h1);
    rd_chk("ar_reload", C_BASE + 32'h10, 32'd2);
    wr(C_BASE + 32'h14, 32'h1, 1'b0);
    chk("ar_irq_drop", {31'h0, timer_irq}, 32'h0);
    cyc(10);
    chk("ar_irq_still_low", {31'h0, timer_irq}, 32'h0);
    cyc(1);
    chk("ar_irq2", {31'h0, timer_irq}, 32'h1);

    // 5. W1C in the same cycle as an expiry tick
    cyc(11);
    rd_chk("col_pre_count", C_BASE + 32'h10, 32'd0);
    wr(C_BASE + 32'h14, 32'h1, 1'b0);
    rd_chk("col_expired", C_BASE + 32'h14, 32'd1);
    rd_chk("col_reload", C_BASE + 32'h10, 32'd2);

    // 6. Reset mid-count
    wr(C_BASE + 32'h08, 32'h0, 1'b0);
    wr(C_BASE + 32'h14, 32'h1, 1'b0);
    wr(C_BASE + 32'h0C, 32'd5, 1'b0);
    wr(C_BASE + 32'h08, 32'h1, 1'b0);
    cyc(2);
    rd_chk("mr_count5", C_BASE + 32'h10, 32'd5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    rd_chk("mr_count", C_BASE + 32'h10, 32'd0);
    rd_chk("mr_ctrl", C_BASE + 32'h08, 32'd0);
    rd_chk("mr_load", C_BASE + 32'h0C, 32'd0);
    rd_chk("mr_status", C_BASE + 32'h14, 32'd0);
    chk("mr_gpio_out", gpio_out, 32'h0);
    chk("mr_irq", {31'h0, timer_irq}, 32'h0);
    cyc(20);
    rd_chk("mr_no_tick_cnt", C_BASE + 32'h10, 32'd0);
    rd_chk("mr_no_tick_st", C_BASE + 32'h14, 32'd0);

    // 7. Unmapped offset
    wr(C_BASE, 32'h55, 1'b0);
    wr(C_BASE + 32'h3C, 32'hFFFF_FFFF, 1'b0);
    rd_chk("um_read", C_BASE + 32'h3C, 32'h0);
    chk("um_gpio_out", gpio_out, 32'h55);
    rd_chk("um_ctrl", C_BASE + 32'h08, 32'h0);
    rd_chk("um_load", C_BASE + 32'h0C, 32'h0);
    rd_chk("um_status", C_BASE + 32'h14, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_io_bridge
`default_nettype wire

// File: doc/io_bridge.md
Name: io_bridge

Overview:
Memory-mapped I/O bridge on the core's data-memory port, between the mips core and dmem. It decodes each access address. Addresses inside the I/O window go to local peripheral registers: GPIO out/in and a programmable down-counting timer with interrupt. All other addresses pass straight through to dmem. Writes take effect on the clock edge and reads are combinational, so the single-cycle core needs no stall.

Parameters:
IO_BASE, 32'hFFFF_FF00, base of the 256-byte I/O window; decode compares addr[31:8] with IO_BASE[31:8].
PRESCALE, 4, clock cycles per timer tick (must be ≥1).
MEM_AW, 10, width of the address forwarded to dmem.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high.
we  in  1  core store strobe.
addr  in  32  core byte address (ALU result).
wd  in  32  core store data.
rd  out  32  load data returned to core.
mem_we  out  1  dmem write enable.
mem_addr  out  MEM_AW  dmem address, equal to addr[MEM_AW-1:0].
mem_wd  out  32  dmem write data, equal to wd.
mem_rd  in  32  dmem read data.
gpio_in  in  32  asynchronous external inputs.
gpio_out  out  32  GPIO output register.
timer_irq  out  1  level interrupt, equal to STATUS.expired & CTRL.irq_en.

Behaviour:
- Address decode: is_io = (addr[31:8] == IO_BASE[31:8]). Combinational.
- Memory path:
  - mem_we = we & ~is_io.
  - mem_addr and mem_wd pass through unconditionally.
  - rd = is_io ? io_rdata : mem_rd.
- I/O register map, by offset addr[7:0] (word aligned; addr[1:0] ignored):
  - 0x00 GPIO_OUT: RW.
  - 0x04 GPIO_IN: RO. gpio_in passes through a two-flop synchronizer, so a change is visible 2 cycles later.
  - 0x08 CTRL: RW. bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x0C LOAD: RW.
  - 0x10 COUNT: RO.
  - 0x14 STATUS: bit0 expired, write-1-to-clear.
  - Any other offset reads 32'h0; writes to it are ignored. Writes to RO registers are ignored.
- Reset values: gpio_out=0, CTRL=0, LOAD=0, COUNT=0, expired=0, prescaler=0, sync flops=0, timer_irq=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - tick is asserted in the cycle the prescaler equals PRESCALE-1, after which it wraps to 0.
  - Forced to 0 while en=0.
- Timer, evaluated on tick:
  - COUNT>0: COUNT decrements by 1.
  - COUNT==0: expired is set.
    - If auto_reload=1, COUNT<=LOAD.
    - If auto_reload=0, en is cleared and COUNT stays 0.
- A write to LOAD also loads COUNT<=wd in the same edge. This write takes priority over a tick decrement in that cycle.
- Simultaneous events:
  - Hardware set of expired and a W1C in the same cycle: set wins, so expired stays 1.
  - CTRL write and a hardware clear of en in the same cycle: the software write wins.
- Enabling with COUNT==0: the first tick sets expired, so the first interrupt arrives PRESCALE cycles after the CTRL write edge.
- Reset mid-operation: all state returns to its reset values on the next edge. No tick or expiry occurs in that cycle.
- COUNT never underflows. Width is 32 bits unsigned.

Decomposition:
- Add to global_types:
  - IO register offset constants (IO_GPIO_OUT, IO_GPIO_IN, IO_CTRL, IO_LOAD, IO_COUNT, IO_STATUS).
  - CTRL bit-index constants.
  - A packed struct typedef timer_ctrl_t {irq_en, auto_reload, en}.
- One sub-module, io_timer: holds the prescaler, COUNT, LOAD, CTRL and expired, and drives timer_irq.
- io_bridge keeps the address decode, GPIO registers, synchronizer and read mux.

Test Plan:
1. Pass-through: store wd=32'hDEADBEEF to addr=0x40, then load 0x40. Expect mem_we=1 during the store, mem_addr=0x040, and rd=32'hDEADBEEF on the load.
2. GPIO:
   - Write 32'hA5A5_0F0F to IO_BASE+0x00: gpio_out updates on that edge and mem_we=0.
   - Drive gpio_in=32'h1234: a read of IO_BASE+0x04 returns 0x1234 from the 2nd cycle after the change.
3. One-shot timer, PRESCALE=4:
   - Write LOAD=3, then CTRL=0x5 (en, irq_en).
   - Expect COUNT to step 3,2,1,0 on every 4th cycle, then expired=1 and timer_irq=1 on the next tick.
   - Expect CTRL.en to read back 0 and COUNT to stay 0.
4. Auto-reload: LOAD=2, CTRL=0x7. Expect expired to set every 3 ticks (12 cycles). After a W1C of 0x1 to STATUS, timer_irq drops the next cycle and re-asserts 12 cycles later.
5. W1C collision: issue the STATUS write of 0x1 in the exact cycle of an expiry tick. Expect expired=1 after the edge.
6. Reset mid-count: assert reset for 1 cycle while COUNT=5 and en=1. Expect all registers 0, timer_irq=0, and no further ticks until CTRL is rewritten.
7. Unmapped offset: a read of IO_BASE+0x3C returns 0, and a write to it changes no state and keeps mem_we=0.
